// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store alignment unit: funct3 encodings,
// FSM states and small decode helpers.
package lsu_pkg;

    localparam logic [2:0] F3_LB  = 3'd0;
    localparam logic [2:0] F3_LH  = 3'd1;
    localparam logic [2:0] F3_LW  = 3'd2;
    localparam logic [2:0] F3_LD  = 3'd3;
    localparam logic [2:0] F3_LBU = 3'd4;
    localparam logic [2:0] F3_LHU = 3'd5;
    localparam logic [2:0] F3_LWU = 3'd6;
    localparam logic [2:0] F3_SB  = 3'd0;
    localparam logic [2:0] F3_SH  = 3'd1;
    localparam logic [2:0] F3_SW  = 3'd2;
    localparam logic [2:0] F3_SD  = 3'd3;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ISSUE0 = 3'd1,
        ST_WAIT0  = 3'd2,
        ST_ISSUE1 = 3'd3,
        ST_WAIT1  = 3'd4,
        ST_RESP   = 3'd5
    } lsu_state_e;

    // Access size in bytes.
    function automatic logic [3:0] lsu_size(input logic [2:0] f3);
        if (f3 == F3_LB || f3 == F3_LBU || f3 == F3_SB) return 4'd1;
        if (f3 == F3_LH || f3 == F3_LHU || f3 == F3_SH) return 4'd2;
        if (f3 == F3_LW || f3 == F3_LWU || f3 == F3_SW) return 4'd4;
        return 4'd8;
    endfunction

    function automatic logic lsu_signed(input logic [2:0] f3);
        return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW);
    endfunction

    function automatic logic lsu_illegal(input logic we, input logic [2:0] f3, input int xlen);
        return (f3 == 3'd7) || (we && (f3 > F3_SD)) ||
               ((xlen == 32) && ((f3 == F3_LD) || (f3 == F3_LWU)));
    endfunction

endpackage

// File: rtl/lsu_lane_shift.sv
// Combinational byte-lane steering: store write mask / shifted data for a
// beat, and placement of load bytes from a cache word into result order.
module lsu_lane_shift #(
    parameter int XLEN = 32
) (
    input  logic [$clog2(XLEN/8)-1:0] offset,
    input  logic [3:0]                size,
    input  logic                      beat,
    input  logic [XLEN-1:0]           wdata,
    input  logic [XLEN-1:0]           rdata,
    output logic [XLEN/8-1:0]         we_mask,
    output logic [XLEN-1:0]           din,
    output logic [XLEN-1:0]           ld_bytes
);
    localparam int W  = XLEN / 8;
    localparam int OW = $clog2(W);

    int lo;
    int hi;
    int wo;
    logic [OW-1:0] src;
    logic [OW-1:0] rl;

    always_comb begin
        we_mask  = '0;
        din      = '0;
        ld_bytes = '0;
        src      = '0;
        rl       = '0;
        lo = beat ? 0 : int'(offset);
        hi = int'(offset) + int'(size) - (beat ? W : 0);
        if (hi > W) hi = W;
        wo = W - int'(offset);
        for (int i = 0; i < W; i++) begin
            // Both beats map lane i to request byte (i - offset) mod W.
            src = OW'(i) - offset;
            if (i >= lo && i < hi) begin
                we_mask[i]     = 1'b1;
                din[8*i +: 8]  = wdata[8*src +: 8];
            end
            rl = OW'(i) + offset;
            if (beat ? (i >= wo) : (i < wo)) ld_bytes[8*i +: 8] = rdata[8*rl +: 8];
        end
    end

endmodule

// File: rtl/lsu_align.sv
// Load/store alignment unit with valid/ready cache handshake.
// Optional macro LSU_MISALIGN_SPLIT_EN: misaligned accesses are executed
// (word-crossing ones as two beats) instead of faulting.
module lsu_align
    import lsu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [2:0]          req_funct3,
    input  logic [XLEN-1:0]     req_addr,
    input  logic [XLEN-1:0]     req_wdata,
    output logic                mem_valid,
    input  logic                mem_ready,
    output logic [XLEN-1:0]     mem_addr,
    output logic [XLEN/8-1:0]   mem_we,
    output logic [XLEN-1:0]     mem_din,
    input  logic                mem_rvalid,
    input  logic [XLEN-1:0]     mem_dout,
    output logic                resp_valid,
    output logic [XLEN-1:0]     resp_data,
    output logic                resp_fault
);
    localparam int W  = XLEN / 8;
    localparam int OW = $clog2(W);

    lsu_state_e state_q, state_d;
    logic            we_q, we_d, fault_q, fault_d;
    logic [2:0]      f3_q, f3_d;
    logic [XLEN-1:0] addr_q, addr_d, wdata_q, wdata_d, data_q, data_d;

    logic [3:0]      req_size, size;
    logic            req_mis, req_fault, split, beat1, issuing, sgn, fill;
    logic [W-1:0]    lane_we;
    logic [XLEN-1:0] lane_din, ld_bytes, ld_ext;
    int              n;

    assign req_size = lsu_size(req_funct3);
    assign req_mis  = |({{(4-OW){1'b0}}, req_addr[OW-1:0]} & (req_size - 4'd1));
    assign size     = lsu_size(f3_q);
    assign beat1    = (state_q == ST_ISSUE1) || (state_q == ST_WAIT1);
    assign issuing  = (state_q == ST_ISSUE0) || (state_q == ST_ISSUE1);

`ifdef LSU_MISALIGN_SPLIT_EN
    logic [4:0] end5;
    assign end5      = 5'(addr_q[OW-1:0]) + 5'(size);
    assign split     = end5 > 5'(W);
    assign req_fault = lsu_illegal(req_we, req_funct3, XLEN);
`else
    assign split     = 1'b0;
    assign req_fault = lsu_illegal(req_we, req_funct3, XLEN) || req_mis;
`endif

    lsu_lane_shift #(.XLEN(XLEN)) u_lane (
        .offset   (addr_q[OW-1:0]),
        .size     (size),
        .beat     (beat1),
        .wdata    (wdata_q),
        .rdata    (mem_dout),
        .we_mask  (lane_we),
        .din      (lane_din),
        .ld_bytes (ld_bytes)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            we_q    <= 1'b0;
            fault_q <= 1'b0;
            f3_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            fault_q <= fault_d;
            f3_q    <= f3_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:   if (req_valid) state_d = req_fault ? ST_RESP : ST_ISSUE0;
            ST_ISSUE0: if (mem_ready) state_d = !we_q ? ST_WAIT0 : (split ? ST_ISSUE1 : ST_RESP);
            ST_WAIT0:  if (mem_rvalid) state_d = split ? ST_ISSUE1 : ST_RESP;
            ST_ISSUE1: if (mem_ready) state_d = we_q ? ST_RESP : ST_WAIT1;
            ST_WAIT1:  if (mem_rvalid) state_d = ST_RESP;
            ST_RESP:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Request capture and little-endian assembly of load bytes across beats.
    always_comb begin
        we_d    = we_q;
        fault_d = fault_q;
        f3_d    = f3_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        data_d  = data_q;
        if (state_q == ST_IDLE && req_valid) begin
            we_d    = req_we;
            fault_d = req_fault;
            f3_d    = req_funct3;
            addr_d  = req_addr;
            wdata_d = req_wdata;
            data_d  = '0;
        end else if ((state_q == ST_WAIT0 || state_q == ST_WAIT1) && mem_rvalid) begin
            data_d = data_q | ld_bytes;
        end
    end

    always_comb begin
        n   = int'(size);
        sgn = 1'b0;
        for (int j = 0; j < W; j++) begin
            if (j == n - 1) sgn = data_q[8*j+7];
        end
        fill = lsu_signed(f3_q) && sgn;
        for (int j = 0; j < W; j++) begin
            ld_ext[8*j +: 8] = (j < n) ? data_q[8*j +: 8] : {8{fill}};
        end
    end

    always_comb begin
        req_ready  = (state_q == ST_IDLE);
        mem_valid  = issuing;
        mem_addr   = '0;
        mem_we     = '0;
        mem_din    = '0;
        resp_valid = (state_q == ST_RESP);
        resp_fault = (state_q == ST_RESP) && fault_q;
        resp_data  = '0;
        if (issuing) begin
            mem_addr = {addr_q[XLEN-1:OW], {OW{1'b0}}} + (beat1 ? XLEN'(W) : '0);
            if (we_q) begin
                mem_we  = lane_we;
                mem_din = lane_din;
            end
        end
        if (state_q == ST_RESP && !we_q && !fault_q) resp_data = ld_ext;
    end

endmodule

// File: tb/tb_lsu_align.sv
// Directed self-checking bench for lsu_align (XLEN=32); split-mode vectors
// are selected with LSU_MISALIGN_SPLIT_EN to match the RTL build.
module tb_lsu_align;
    localparam int XLEN = 32;
    localparam int W    = XLEN / 8;

    logic            clk, rst_n;
    logic            req_valid, req_ready, req_we;
    logic [2:0]      req_funct3;
    logic [XLEN-1:0] req_addr, req_wdata;
    logic            mem_valid, mem_ready, mem_rvalid;
    logic [XLEN-1:0] mem_addr, mem_din, mem_dout;
    logic [W-1:0]    mem_we;
    logic            resp_valid, resp_fault;
    logic [XLEN-1:0] resp_data;

    lsu_align #(.XLEN(XLEN)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .mem_valid  (mem_valid),
        .mem_ready  (mem_ready),
        .mem_addr   (mem_addr),
        .mem_we     (mem_we),
        .mem_din    (mem_din),
        .mem_rvalid (mem_rvalid),
        .mem_dout   (mem_dout),
        .resp_valid (resp_valid),
        .resp_data  (resp_data),
        .resp_fault (resp_fault)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int mv_cnt   = 0;
    int rv_cnt   = 0;
    logic [XLEN-1:0] exp_q[$];

    always @(posedge clk) begin
        if (mem_valid)  mv_cnt++;
        if (resp_valid) rv_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Driver tasks
    task automatic send_req(input logic we, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] wd);
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic beat(input string tag, input logic [31:0] a,
                        input logic [3:0] m, input logic [31:0] d);
        @(negedge clk);
        check({tag, "_mem_valid"}, mem_valid, 1);
        check({tag, "_mem_addr"}, mem_addr, a);
        check({tag, "_mem_we"}, mem_we, m);
        check({tag, "_mem_din"}, mem_din, d);
        mem_ready = 1'b1;
        @(posedge clk);
        #1 mem_ready = 1'b0;
    endtask

    task automatic rdata(input logic [31:0] d);
        @(negedge clk);
        mem_rvalid = 1'b1;
        mem_dout   = d;
        @(posedge clk);
        #1 mem_rvalid = 1'b0;
    endtask

    task automatic resp(input string tag, input logic fault);
        logic [31:0] e;
        @(negedge clk);
        check({tag, "_resp_valid"}, resp_valid, 1);
        check({tag, "_resp_fault"}, resp_fault, fault);
        check({tag, "_sb_depth"}, exp_q.size(), 1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check({tag, "_resp_data"}, resp_data, e);
        end
        @(negedge clk);
        check({tag, "_resp_pulse"}, resp_valid, 0);
        check({tag, "_req_ready"}, req_ready, 1);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_req_ready"}, req_ready, 1);
        check({tag, "_mem_valid"}, mem_valid, 0);
        check({tag, "_mem_addr"}, mem_addr, 0);
        check({tag, "_mem_we"}, mem_we, 0);
        check({tag, "_mem_din"}, mem_din, 0);
        check({tag, "_resp_valid"}, resp_valid, 0);
        check({tag, "_resp_data"}, resp_data, 0);
        check({tag, "_resp_fault"}, resp_fault, 0);
    endtask

    task automatic fault_case(input string tag, input logic we, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] wd);
        int mv0;
        mv0 = mv_cnt;
        exp_q.push_back(32'h0);
        send_req(we, f3, addr, wd);
        resp(tag, 1'b1);
        check({tag, "_no_mem_valid"}, mv_cnt - mv0, 0);
    endtask

    int mv0, rv0;

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0;
        req_addr = '0; req_wdata = '0; mem_ready = 1'b0; mem_rvalid = 1'b0; mem_dout = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check_idle("reset");

        // SB: one beat, store completes with resp two cycles after accept
        exp_q.push_back(32'h0);
        send_req(1'b1, 3'd0, 32'h0000_1003, 32'h0000_00AB);
        beat("sb", 32'h0000_1000, 4'b1000, 32'hAB00_0000);
        resp("sb", 1'b0);

        // SH aligned upper half
        exp_q.push_back(32'h0);
        send_req(1'b1, 3'd1, 32'h0000_A002, 32'h0000_1234);
        beat("sh", 32'h0000_A000, 4'b1100, 32'h1234_0000);
        resp("sh", 1'b0);

        // LH / LHU sign vs zero extension
        exp_q.push_back(32'hFFFF_8001);
        send_req(1'b0, 3'd1, 32'h0000_2002, 32'h0);
        beat("lh", 32'h0000_2000, 4'b0000, 32'h0);
        rdata(32'h8001_7777);
        resp("lh", 1'b0);

        exp_q.push_back(32'h0000_8001);
        send_req(1'b0, 3'd5, 32'h0000_2002, 32'h0);
        beat("lhu", 32'h0000_2000, 4'b0000, 32'h0);
        rdata(32'h8001_7777);
        resp("lhu", 1'b0);

        // LB / LBU
        exp_q.push_back(32'hFFFF_FFF5);
        send_req(1'b0, 3'd0, 32'h0000_8001, 32'h0);
        beat("lb", 32'h0000_8000, 4'b0000, 32'h0);
        rdata(32'h0000_F500);
        resp("lb", 1'b0);

        exp_q.push_back(32'h0000_00F5);
        send_req(1'b0, 3'd4, 32'h0000_8001, 32'h0);
        beat("lbu", 32'h0000_8000, 4'b0000, 32'h0);
        rdata(32'h0000_F500);
        resp("lbu", 1'b0);

        // Aligned LW at minimum latency: mem_valid T+1, rvalid T+2, resp T+3
        exp_q.push_back(32'hCAFE_BABE);
        send_req(1'b0, 3'd2, 32'h0000_4000, 32'h0);
        beat("lw_lat", 32'h0000_4000, 4'b0000, 32'h0);
        rdata(32'hCAFE_BABE);
        resp("lw_lat", 1'b0);

`ifdef LSU_MISALIGN_SPLIT_EN
        exp_q.push_back(32'h1122_3344);
        send_req(1'b0, 3'd2, 32'h0000_3003, 32'h0);
        beat("lw_split0", 32'h0000_3000, 4'b0000, 32'h0);
        rdata(32'h44AA_BBCC);
        beat("lw_split1", 32'h0000_3004, 4'b0000, 32'h0);
        rdata(32'hEE11_2233);
        resp("lw_split", 1'b0);

        exp_q.push_back(32'h0);
        send_req(1'b1, 3'd2, 32'h0000_3002, 32'hDDCC_BBAA);
        beat("sw_split0", 32'h0000_3000, 4'b1100, 32'hBBAA_0000);
        beat("sw_split1", 32'h0000_3004, 4'b0011, 32'h0000_DDCC);
        resp("sw_split", 1'b0);

        exp_q.push_back(32'hFFFF_BEEF);
        send_req(1'b0, 3'd1, 32'h0000_9001, 32'h0);
        beat("lh_mis", 32'h0000_9000, 4'b0000, 32'h0);
        rdata(32'h00BE_EF00);
        resp("lh_mis", 1'b0);

        exp_q.push_back(32'hFFFF_CDAB);
        send_req(1'b0, 3'd1, 32'hFFFF_FFFF, 32'h0);
        beat("lh_wrap0", 32'hFFFF_FFFC, 4'b0000, 32'h0);
        rdata(32'hAB00_0000);
        beat("lh_wrap1", 32'h0000_0000, 4'b0000, 32'h0);
        rdata(32'h0000_00CD);
        resp("lh_wrap", 1'b0);
`else
        fault_case("lw_mis", 1'b0, 3'd2, 32'h0000_3003, 32'h0);
        fault_case("sw_mis", 1'b1, 3'd2, 32'h0000_3002, 32'hDDCC_BBAA);
        fault_case("lh_mis", 1'b0, 3'd1, 32'h0000_9001, 32'h0);
`endif

        // Illegal encodings
        fault_case("ill_st4", 1'b1, 3'd4, 32'h0000_1000, 32'h1);
        fault_case("ill_ld", 1'b0, 3'd3, 32'h0000_1000, 32'h0);
        fault_case("ill_lwu", 1'b0, 3'd6, 32'h0000_1000, 32'h0);
        fault_case("ill_f7", 1'b0, 3'd7, 32'h0000_1000, 32'h0);

        // Stall: mem_ready low, outputs stable, second request ignored
        mv0 = mv_cnt;
        rv0 = rv_cnt;
        exp_q.push_back(32'h1234_5678);
        send_req(1'b0, 3'd2, 32'h0000_5000, 32'h0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("stall%0d_mem_valid", k), mem_valid, 1);
            check($sformatf("stall%0d_mem_addr", k), mem_addr, 32'h0000_5000);
            check($sformatf("stall%0d_req_ready", k), req_ready, 0);
            req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd0;
            req_addr = 32'h0000_6001; req_wdata = 32'hFF;
        end
        req_valid = 1'b0;
        beat("stall", 32'h0000_5000, 4'b0000, 32'h0);
        rdata(32'h1234_5678);
        resp("stall", 1'b0);
        check("stall_mem_valid_cycles", mv_cnt - mv0, 4);
        check("stall_resp_count", rv_cnt - rv0, 1);
        check("stall_no_second_mem_valid", mem_valid, 0);

        // Reset while waiting on load data
        send_req(1'b0, 3'd2, 32'h0000_7000, 32'h0);
        beat("rst_wait", 32'h0000_7000, 4'b0000, 32'h0);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check_idle("rst_mid");
        rv0 = rv_cnt;
        rdata(32'hDEAD_BEEF);
        repeat (3) @(negedge clk);
        check("rst_late_rvalid_no_resp", rv_cnt - rv0, 0);
        check("rst_late_req_ready", req_ready, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
